// File: rtl/snddma_addr_if.sv
// snddma_addr_if: byte-wide CPU register bus of the sound DMA address sequencer.
interface snddma_addr_if;
  logic       reg_wr;
  logic       reg_rd;
  logic [3:0] reg_a;
  logic [7:0] reg_d;
  logic [7:0] reg_q;

  modport master (output reg_wr, reg_rd, reg_a, reg_d, input reg_q);
  modport slave  (input reg_wr, reg_rd, reg_a, reg_d, output reg_q);
endinterface

// File: rtl/snddma_addr.sv
// snddma_addr: sound DMA frame start/end registers, current address counter and
// request pacing for the MCU control block.
// Optional macro SNDDMA_FRIRQ_EN adds the fr_irq pulse and the sticky frame-done
// flag in control readback bit 7.
module snddma_addr #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = 3
) (
  input  logic         clk32,
  input  logic         por,
  snddma_addr_if.slave bus,
  input  logic         word_ld,
  input  logic         smp_take,
  input  logic         fr_end,
  output logic [21:1]  snd,
  output logic [21:1]  sft,
  output logic         sndon,
  output logic         sfrep,
`ifdef SNDDMA_FRIRQ_EN
  output logic         fr_irq,
`endif
  output logic         sreq
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StWrap} state_e;

  localparam logic [LVL_W-1:0] FillFull = LVL_W'(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [21:1]      start_sh_q, start_sh_d;
  logic [21:1]      end_sh_q, end_sh_d;
  logic [21:1]      snd_q, snd_d;
  logic [21:1]      sft_q, sft_d;
  logic [LVL_W-1:0] fill_q, fill_d;
  logic             pend_q, pend_d;
  logic             sndon_q, sndon_d;
  logic             sreq_q, sreq_d;
  logic             done_bit;

  logic ctrl_wr, play_wr, stop_wr;
  assign ctrl_wr = bus.reg_wr && (bus.reg_a == 4'd0);
  assign play_wr = ctrl_wr && bus.reg_d[0];
  assign stop_wr = ctrl_wr && !bus.reg_d[0];

  // State register.
  always_ff @(posedge clk32 or posedge por) begin
    if (por) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; a stop write outranks a simultaneous frame end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (play_wr) state_d = StLoad;
      StLoad: state_d = StRun;
      StRun: begin
        if (stop_wr)     state_d = StIdle;
        else if (fr_end) state_d = StWrap;
      end
      StWrap: state_d = ctrl_q[1] ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Shadow registers, control, address counter and FIFO fill next-state.
  always_comb begin
    start_sh_d = start_sh_q;
    end_sh_d   = end_sh_q;
    ctrl_d     = ctrl_q;
    snd_d      = snd_q;
    sft_d      = sft_q;
    fill_d     = fill_q;
    pend_d     = pend_q;
    if (bus.reg_wr) begin
      case (bus.reg_a)
        4'd0: ctrl_d = bus.reg_d[1:0];
        4'd1: start_sh_d[21:16] = bus.reg_d[5:0];
        4'd2: start_sh_d[15:8]  = bus.reg_d;
        4'd3: start_sh_d[7:1]   = bus.reg_d[7:1];
        4'd4: end_sh_d[21:16]   = bus.reg_d[5:0];
        4'd5: end_sh_d[15:8]    = bus.reg_d;
        4'd6: end_sh_d[7:1]     = bus.reg_d[7:1];
        default: ;
      endcase
    end
    // A non-repeating frame ends the play request.
    if (state_q == StWrap && !ctrl_q[1]) ctrl_d[0] = 1'b0;
    unique case (state_q)
      StIdle: begin
        fill_d = '0;
        pend_d = 1'b0;
      end
      StLoad: begin
        snd_d  = start_sh_q;
        sft_d  = end_sh_q;
        fill_d = '0;
        pend_d = 1'b0;
      end
      default: begin
        if (state_q == StRun && word_ld) snd_d = snd_q + 21'd1;
        if (word_ld && !smp_take && fill_q < FillFull) fill_d = fill_q + LVL_W'(1);
        else if (smp_take && !word_ld && fill_q != '0) fill_d = fill_q - LVL_W'(1);
        pend_d = (state_q == StRun) ? (pend_q | fr_end) : 1'b0;
      end
    endcase
  end

  // Registered outputs; sndon holds across WRAP/LOAD so a repeating stream stays on.
  always_comb begin
    sndon_d = sndon_q;
    if (state_d == StIdle)     sndon_d = 1'b0;
    else if (state_d == StRun) sndon_d = 1'b1;
    sreq_d = (state_d == StRun) && (fill_d < FillFull) && !pend_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      ctrl_q     <= '0;
      start_sh_q <= '0;
      end_sh_q   <= '0;
      snd_q      <= '0;
      sft_q      <= '0;
      fill_q     <= '0;
      pend_q     <= 1'b0;
      sndon_q    <= 1'b0;
      sreq_q     <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      start_sh_q <= start_sh_d;
      end_sh_q   <= end_sh_d;
      snd_q      <= snd_d;
      sft_q      <= sft_d;
      fill_q     <= fill_d;
      pend_q     <= pend_d;
      sndon_q    <= sndon_d;
      sreq_q     <= sreq_d;
    end
  end

`ifdef SNDDMA_FRIRQ_EN
  logic done_q, done_d;
  logic fr_irq_q;

  // Sticky frame-done flag; a WRAP outranks a simultaneous read clear.
  always_comb begin
    done_d = done_q;
    if (bus.reg_rd && bus.reg_a == 4'd0) done_d = 1'b0;
    if (state_q == StWrap)               done_d = 1'b1;
  end

  // Frame-done flag and interrupt pulse registers.
  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      done_q   <= 1'b0;
      fr_irq_q <= 1'b0;
    end else begin
      done_q   <= done_d;
      fr_irq_q <= (state_d == StWrap);
    end
  end

  assign done_bit = done_q;
  assign fr_irq   = fr_irq_q;
`else
  logic unused_reg_rd;
  assign unused_reg_rd = bus.reg_rd;
  assign done_bit      = 1'b0;
`endif

  assign snd   = snd_q;
  assign sft   = sft_q;
  assign sndon = sndon_q;
  assign sfrep = ctrl_q[1];
  assign sreq  = sreq_q;

  // Combinational register readback.
  always_comb begin
    case (bus.reg_a)
      4'd0:    bus.reg_q = {done_bit, 5'b0, ctrl_q};
      4'd1:    bus.reg_q = {2'b0, start_sh_q[21:16]};
      4'd2:    bus.reg_q = start_sh_q[15:8];
      4'd3:    bus.reg_q = {start_sh_q[7:1], 1'b0};
      4'd4:    bus.reg_q = {2'b0, end_sh_q[21:16]};
      4'd5:    bus.reg_q = end_sh_q[15:8];
      4'd6:    bus.reg_q = {end_sh_q[7:1], 1'b0};
      4'd7:    bus.reg_q = {2'b0, snd_q[21:16]};
      4'd8:    bus.reg_q = snd_q[15:8];
      4'd9:    bus.reg_q = {snd_q[7:1], 1'b0};
      default: bus.reg_q = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_snddma_addr.sv
// tb_snddma_addr: directed scoreboard bench for snddma_addr.
module tb_snddma_addr;
  logic        clk32 = 1'b0;
  logic        por;
  logic        word_ld, smp_take, fr_end;
  logic [21:1] snd, sft;
  logic        sndon, sfrep, sreq;
`ifdef SNDDMA_FRIRQ_EN
  logic        fr_irq;
`endif

  snddma_addr_if bus ();

  snddma_addr #(.FIFO_DEPTH(4), .LVL_W(3)) dut (
    .clk32    (clk32),
    .por      (por),
    .bus      (bus.slave),
    .word_ld  (word_ld),
    .smp_take (smp_take),
    .fr_end   (fr_end),
    .snd      (snd),
    .sft      (sft),
    .sndon    (sndon),
    .sfrep    (sfrep),
`ifdef SNDDMA_FRIRQ_EN
    .fr_irq   (fr_irq),
`endif
    .sreq     (sreq)
  );

  always #5 clk32 = ~clk32;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=%0h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.reg_a  = a;
    bus.reg_d  = d;
    bus.reg_wr = 1'b1;
    tick();
    bus.reg_wr = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] q);
    bus.reg_a = a;
    #1;
    q = bus.reg_q;
  endtask

  logic [7:0] rq;

  initial begin
    por          = 1'b1;
    word_ld      = 1'b0;
    smp_take     = 1'b0;
    fr_end       = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.reg_rd   = 1'b0;
    bus.reg_a    = 4'd0;
    bus.reg_d    = 8'd0;
    #2;
    // Reset state.
    push("rst_snd", 0); push("rst_sft", 0); push("rst_sndon", 0);
    push("rst_sfrep", 0); push("rst_sreq", 0); push("rst_ctrl", 0);
    peek(4'd0, rq);
    pop_chk(snd); pop_chk(sft); pop_chk(sndon); pop_chk(sfrep); pop_chk(sreq); pop_chk(rq);
    tick();
    por = 1'b0;

    // Start 0x012340, end 0x012350, play.
    wr(4'd1, 8'h01); wr(4'd2, 8'h23); wr(4'd3, 8'h40);
    wr(4'd4, 8'h01); wr(4'd5, 8'h23); wr(4'd6, 8'h50);
    wr(4'd0, 8'h01);
    push("sndon_in_load", 0); pop_chk(sndon);
    push("snd_first", 21'h0091A0); push("sft_first", 21'h0091A8);
    push("sndon_run", 1); push("sreq_run", 1);
    tick();
    pop_chk(snd); pop_chk(sft); pop_chk(sndon); pop_chk(sreq);
    push("rd_snd_mid", 8'h23); peek(4'd8, rq); pop_chk(rq);
    push("rd_snd_lo", 8'h40);  peek(4'd9, rq); pop_chk(rq);

    // Fill the FIFO; sreq drops right after the fourth word.
    word_ld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("sreq_fill", (i < 3) ? 1 : 0);
      tick();
      pop_chk(sreq);
    end
    push("snd_after4", 21'h0091A4); pop_chk(snd);
    // One more word while full: count saturates, address still advances.
    push("snd_sat", 21'h0091A5); push("sreq_sat", 0);
    tick();
    word_ld = 1'b0;
    pop_chk(snd); pop_chk(sreq);
    smp_take = 1'b1;
    push("sreq_after_take", 1);
    tick();
    smp_take = 1'b0;
    pop_chk(sreq);
    // Load and take together leave the count alone.
    word_ld = 1'b1; smp_take = 1'b1;
    push("sreq_both", 1);
    tick();
    smp_take = 1'b0;
    pop_chk(sreq);
    push("sreq_refull", 0); push("snd_refull", 21'h0091A7);
    tick();
    word_ld = 1'b0;
    pop_chk(sreq); pop_chk(snd);

    // Repeat mode, new start shadow mid-frame.
    wr(4'd0, 8'h03);
    push("sfrep_on", 1); push("sndon_still", 1); pop_chk(sfrep); pop_chk(sndon);
    wr(4'd1, 8'h02); wr(4'd2, 8'h00); wr(4'd3, 8'h00);
    push("sft_no_early_load", 21'h0091A8); push("snd_no_early_load", 21'h0091A7);
    pop_chk(sft); pop_chk(snd);
    fr_end = 1'b1;
    tick();
    fr_end = 1'b0;
    push("wrap_sndon", 1); push("wrap_sreq", 0); push("wrap_sft", 21'h0091A8);
    pop_chk(sndon); pop_chk(sreq); pop_chk(sft);
    tick();
    push("load_sndon", 1); pop_chk(sndon);
    tick();
    push("rep_snd", 21'h010000); push("rep_sft", 21'h0091A8);
    push("rep_sndon", 1); push("rep_sreq", 1);
    pop_chk(snd); pop_chk(sft); pop_chk(sndon); pop_chk(sreq);

    // No repeat; fr_end with word_ld increments then wraps to IDLE.
    wr(4'd0, 8'h01);
    push("sfrep_off", 0); pop_chk(sfrep);
    fr_end = 1'b1; word_ld = 1'b1;
    tick();
    fr_end = 1'b0; word_ld = 1'b0;
    push("snd_inc_at_end", 21'h010001); pop_chk(snd);
    tick();
    push("idle_sndon", 0); push("idle_sreq", 0); push("idle_ctrl", 8'h00);
    pop_chk(sndon); pop_chk(sreq);
    peek(4'd0, rq); pop_chk(rq);

    // Stop write beats a simultaneous fr_end.
    wr(4'd0, 8'h01);
    tick();
    push("stop_pre_sndon", 1); pop_chk(sndon);
    bus.reg_a = 4'd0; bus.reg_d = 8'h00; bus.reg_wr = 1'b1; fr_end = 1'b1;
    tick();
    bus.reg_wr = 1'b0; fr_end = 1'b0;
    push("stop_wins_sndon", 0); pop_chk(sndon);
    tick(); tick();
    push("stop_stays_idle", 0); pop_chk(sndon);

    // Reset in the middle of a frame.
    wr(4'd1, 8'h01); wr(4'd2, 8'h23); wr(4'd3, 8'h40);
    wr(4'd0, 8'h03);
    tick();
    word_ld = 1'b1;
    repeat (4) tick();
    word_ld = 1'b0;
    smp_take = 1'b1;
    tick();
    smp_take = 1'b0;
    push("pre_por_snd", 21'h0091A4); push("pre_por_sreq", 1); push("pre_por_sfrep", 1);
    pop_chk(snd); pop_chk(sreq); pop_chk(sfrep);
    por = 1'b1;
    #1;
    push("por_snd", 0); push("por_sft", 0); push("por_sndon", 0);
    push("por_sfrep", 0); push("por_sreq", 0);
    pop_chk(snd); pop_chk(sft); pop_chk(sndon); pop_chk(sfrep); pop_chk(sreq);
    por = 1'b0;
    tick(); tick();
    push("post_por_sndon", 0); push("post_por_snd", 0);
    pop_chk(sndon); pop_chk(snd);

    // Top address bits ignored, counter wraps modulo 2^21.
    wr(4'd1, 8'hFF); wr(4'd2, 8'hFF); wr(4'd3, 8'hFF);
    push("rd_start_hi", 8'h3F); peek(4'd1, rq); pop_chk(rq);
    push("rd_start_lo", 8'hFE); peek(4'd3, rq); pop_chk(rq);
    push("rd_unmapped", 8'h00); peek(4'd10, rq); pop_chk(rq);
    wr(4'd0, 8'h01);
    tick();
    push("snd_top", 21'h1FFFFF); pop_chk(snd);
    word_ld = 1'b1;
    tick();
    word_ld = 1'b0;
    push("snd_wrap0", 0); pop_chk(snd);
    wr(4'd0, 8'h00);
    tick();

`ifdef SNDDMA_FRIRQ_EN
    // Frame interrupt and sticky done flag.
    wr(4'd0, 8'h03);
    tick();
    fr_end = 1'b1;
    tick();
    fr_end = 1'b0;
    push("irq_in_wrap", 1); pop_chk(fr_irq);
    tick();
    push("irq_after_wrap", 0); pop_chk(fr_irq);
    push("done_set", 8'h83); peek(4'd0, rq); pop_chk(rq);
    bus.reg_a = 4'd0; bus.reg_rd = 1'b1;
    tick();
    bus.reg_rd = 1'b0;
    push("done_clr", 8'h03); peek(4'd0, rq); pop_chk(rq);
    fr_end = 1'b1;
    tick();
    fr_end = 1'b0;
    bus.reg_a = 4'd0; bus.reg_rd = 1'b1;
    tick();
    bus.reg_rd = 1'b0;
    push("done_set_wins", 8'h83); peek(4'd0, rq); pop_chk(rq);
    wr(4'd0, 8'h00);
`endif

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
